// File: rtl/store_axi_wr_if.sv
// Single-beat AXI write channel bundle (AW, W, B) between a store master and memory.
// Latency: none, wires only.
// Backpressure: awready/wready/bvalid from the slave gate the master's handshakes.
interface store_axi_wr_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/store_axi_wr.sv
// Store-side AXI write master: formats a MEM-stage store and issues one single-beat AW/W/B write.
// Latency: 3 cycles request-to-done with ready slave (2 with STORE_POSTED_EN, B tracked in background).
// Backpressure: st_stall holds the pipeline until DONE; AW/W held valid until their ready.
module store_axi_wr #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  st_req,
    input  logic [31:0]           st_addr,
    input  logic [3:0]            st_we,
    input  logic [31:0]           st_rt,
    output logic                  st_stall,
    output logic                  st_berr,
    store_axi_wr_if.master        axi
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } wr_cmd_t;

    state_t  state;
    wr_cmd_t cmd;
    wr_cmd_t fmt;
    logic    legal_we;
    logic    legal;
    logic    accept;
    logic    aw_fin;
    logic    w_fin;
    logic    unused_bid;

    always_comb begin
        case (st_we)
            4'b1111, 4'b1000, 4'b0100, 4'b0010,
            4'b0001, 4'b1100, 4'b0011: legal_we = 1'b1;
            default:                   legal_we = 1'b0;
        endcase
    end

    assign legal    = st_req & legal_we;
    assign st_stall = legal & (state != DONE);

    // kseg0/kseg1 strip to physical; everything else passes through untranslated
    always_comb begin
        fmt.addr = (st_addr[31:30] == 2'b10) ? {3'b000, st_addr[28:0]} : st_addr;
        fmt.strb = {st_we[0], st_we[1], st_we[2], st_we[3]};
        case (st_we)
            4'b1111: begin
                fmt.data = st_rt;
                fmt.size = 3'd2;
            end
            4'b1100, 4'b0011: begin
                fmt.data = {2{st_rt[15:0]}};
                fmt.size = 3'd1;
            end
            default: begin
                fmt.data = {4{st_rt[7:0]}};
                fmt.size = 3'd0;
            end
        endcase
    end

    // A channel counts as finished if it already completed or completes this cycle
    assign aw_fin = ~axi.awvalid | axi.awready;
    assign w_fin  = ~axi.wvalid  | axi.wready;

`ifdef STORE_POSTED_EN
    logic b_pending;
    logic b_hs;

    assign b_hs       = axi.bvalid & axi.bready;
    assign accept     = legal & (~b_pending | b_hs);
    assign axi.bready = b_pending | (state == RESP);
    assign st_berr    = b_hs & (axi.bresp != 2'b00);
`else
    logic berr_q;

    assign accept     = legal;
    assign axi.bready = (state == RESP);
    assign st_berr    = berr_q;
`endif

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state       <= IDLE;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            cmd         <= '0;
`ifdef STORE_POSTED_EN
            b_pending   <= 1'b0;
`else
            berr_q      <= 1'b0;
`endif
        end else begin
`ifdef STORE_POSTED_EN
            if (b_hs) begin
                b_pending <= 1'b0;
            end
`else
            berr_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd         <= fmt;
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.awready) begin
                        axi.awvalid <= 1'b0;
                    end
                    if (axi.wready) begin
                        axi.wvalid <= 1'b0;
                    end
                    if (aw_fin & w_fin) begin
`ifdef STORE_POSTED_EN
                        b_pending <= 1'b1;
                        state     <= DONE;
`else
                        state     <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (axi.bvalid) begin
`ifndef STORE_POSTED_EN
                        berr_q <= (axi.bresp != 2'b00);
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign axi.awid    = AXI_ID;
    assign axi.wid     = AXI_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awburst = 2'b01;
    assign axi.wlast   = 1'b1;
    assign axi.awaddr  = cmd.addr;
    assign axi.awsize  = cmd.size;
    assign axi.wdata   = cmd.data;
    assign axi.wstrb   = cmd.strb;

    assign unused_bid  = ^axi.bid;

endmodule

// File: tb/tb_store_axi_wr.sv
// Bench for store_axi_wr: directed stores from the test plan plus randomized stores,
// all checked each cycle against a transaction-level model of the store protocol.
module tb_store_axi_wr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_req;
    logic [31:0] st_addr;
    logic [3:0]  st_we;
    logic [31:0] st_rt;
    logic        st_stall;
    logic        st_berr;

    always #5 clk = ~clk;

    store_axi_wr_if axi();

    store_axi_wr #(.AXI_ID(4'd1)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .st_req      (st_req),
        .st_addr     (st_addr),
        .st_we       (st_we),
        .st_rt       (st_rt),
        .st_stall    (st_stall),
        .st_berr     (st_berr),
        .axi         (axi)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- specification rules ----------------
    function automatic bit is_legal(input logic [3:0] we);
        return (we == 4'b1111) || (we == 4'b1100) || (we == 4'b0011) || ($countones(we) == 1);
    endfunction

    function automatic logic [31:0] phys(input logic [31:0] a);
        logic [31:0] p;
        p = a;
        if (a[31:30] == 2'b10) p[31:29] = 3'b000;
        return p;
    endfunction

    function automatic logic [31:0] lane_data(input logic [3:0] we, input logic [31:0] rt);
        int n;
        n = $countones(we);
        if (n == 4) return rt;
        if (n == 2) return {rt[15:0], rt[15:0]};
        return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    endfunction

    function automatic logic [2:0] size_of(input logic [3:0] we);
        int n;
        n = $countones(we);
        return (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [3:0] strb_of(input logic [3:0] we);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = we[3-i];
        return s;
    endfunction

    // ---------------- AXI slave ----------------
    int         aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    int         aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!axi.awvalid) aw_cnt = 0;
            axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
            if (axi.awvalid) aw_cnt++;
            if (!axi.wvalid) w_cnt = 0;
            axi.wready = axi.wvalid && (w_cnt >= w_dly);
            if (axi.wvalid) w_cnt++;
            if (!axi.bready) begin
                b_cnt = 0;
                axi.bvalid = 1'b0;
                axi.bresp = 2'b00;
            end else begin
                axi.bvalid = (b_cnt >= b_dly);
                axi.bresp = axi.bvalid ? b_resp_cfg : 2'b00;
                b_cnt++;
            end
            axi.bid = 4'($urandom_range(0, 15));
        end
    end

    // ---------------- model + per-cycle compare ----------------
    bit          m_active = 0, m_aw = 0, m_w = 0, m_done = 0;
    logic [1:0]  m_prev_bresp = 2'b00;
    logic [31:0] e_addr = '0, e_data = '0;
    logic [3:0]  e_strb = '0;
    logic [2:0]  e_size = '0;
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic [3:0]  cap_strb = '0;
    logic [2:0]  cap_size = '0;
    int          n_aw = 0, n_w = 0, n_berr = 0, n_awv = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_awvalid", axi.awvalid, 0);
                chk("rst_wvalid", axi.wvalid, 0);
                chk("rst_bready", axi.bready, 0);
                chk("rst_berr", st_berr, 0);
                chk("rst_awaddr", axi.awaddr, 0);
                chk("rst_wdata", axi.wdata, 0);
                chk("rst_wstrb", axi.wstrb, 0);
                chk("rst_awsize", axi.awsize, 0);
                m_active = 0; m_aw = 0; m_w = 0; m_done = 0; m_prev_bresp = 2'b00;
            end else begin
                bit legal, aw_hs, w_hs, b_hs;
                legal = st_req && is_legal(st_we);
                chk("stall", st_stall, legal && !m_done);
                chk("berr", st_berr, m_done && (m_prev_bresp != 2'b00));
                chk("awvalid", axi.awvalid, m_active && !m_aw);
                chk("wvalid", axi.wvalid, m_active && !m_w);
                chk("bready", axi.bready, m_active && m_aw && m_w);
                chk("awid", axi.awid, 1);
                chk("wid", axi.wid, 1);
                chk("awlen", axi.awlen, 0);
                chk("awburst", axi.awburst, 1);
                chk("wlast", axi.wlast, 1);
                if (axi.awvalid) begin
                    chk("awaddr", axi.awaddr, e_addr);
                    chk("awsize", axi.awsize, e_size);
                    cap_addr = axi.awaddr;
                    cap_size = axi.awsize;
                    n_awv++;
                end
                if (axi.wvalid) begin
                    chk("wdata", axi.wdata, e_data);
                    chk("wstrb", axi.wstrb, e_strb);
                    cap_data = axi.wdata;
                    cap_strb = axi.wstrb;
                end
                if (st_berr) n_berr++;
                aw_hs = axi.awvalid && axi.awready;
                w_hs  = axi.wvalid && axi.wready;
                b_hs  = axi.bvalid && axi.bready;
                if (aw_hs) n_aw++;
                if (w_hs) n_w++;
                if (!m_active && !m_done && legal) begin
                    m_active = 1; m_aw = 0; m_w = 0;
                    e_addr = phys(st_addr);
                    e_data = lane_data(st_we, st_rt);
                    e_strb = strb_of(st_we);
                    e_size = size_of(st_we);
                end else if (m_active) begin
                    if (aw_hs) m_aw = 1;
                    if (w_hs) m_w = 1;
                    if (b_hs) m_active = 0;
                end
                m_done = b_hs;
                m_prev_bresp = axi.bresp;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Entered and left at posedge+1; holds st_req until the stall drops.
    task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] rt,
                            output int sc);
        int guard;
        sc = 0;
        guard = 0;
        st_addr = a; st_we = we; st_rt = rt; st_req = 1'b1;
        if (!is_legal(we)) begin
            repeat (3) begin
                #1;
                if (st_stall) sc++;
                @(posedge clk);
                #1;
            end
        end else begin
            forever begin
                #1;
                if (!st_stall) break;
                sc++;
                guard++;
                if (guard > 300) begin
                    chk("store_timeout", 1, 0);
                    break;
                end
                @(posedge clk);
                #1;
                st_addr = $urandom;
                st_rt = $urandom;
            end
            @(posedge clk);
            #1;
        end
        st_req = 1'b0;
    endtask

    initial begin
        int sc, aw0, w0, be0, awv0, k;
        logic [31:0] a;
        logic [3:0]  we;
        st_req = 1'b0; st_addr = '0; st_we = '0; st_rt = '0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word store through kseg0
        do_store(32'h8000_0010, 4'b1111, 32'h1234_5678, sc);
        chk("sw_stall_cycles", sc, 3);
        chk("sw_awaddr", cap_addr, 32'h0000_0010);
        chk("sw_wdata", cap_data, 32'h1234_5678);
        chk("sw_wstrb", cap_strb, 4'b1111);
        chk("sw_awsize", cap_size, 3'd2);

        // byte store through kseg1
        do_store(32'hBFAF_F002, 4'b0010, 32'h0000_00A5, sc);
        chk("sb_stall_cycles", sc, 3);
        chk("sb_awaddr", cap_addr, 32'h1FAF_F002);
        chk("sb_wdata", cap_data, 32'hA5A5_A5A5);
        chk("sb_wstrb", cap_strb, 4'b0100);
        chk("sb_awsize", cap_size, 3'd0);

        // half store with W accepted 4 cycles after AW
        w_dly = 4;
        aw0 = n_aw; w0 = n_w;
        do_store(32'h0000_1002, 4'b1100, 32'hFFFF_BEEF, sc);
        w_dly = 0;
        chk("sh_stall_cycles", sc, 7);
        chk("sh_awaddr", cap_addr, 32'h0000_1002);
        chk("sh_wdata", cap_data, 32'hBEEF_BEEF);
        chk("sh_wstrb", cap_strb, 4'b0011);
        chk("sh_awsize", cap_size, 3'd1);
        chk("sh_aw_count", n_aw - aw0, 1);
        chk("sh_w_count", n_w - w0, 1);

        // delayed error response
        b_dly = 5; b_resp_cfg = 2'b10;
        be0 = n_berr;
        do_store(32'hA000_0100, 4'b1111, 32'hCAFE_F00D, sc);
        b_dly = 0; b_resp_cfg = 2'b00;
        chk("berr_stall_cycles", sc, 8);
        chk("berr_awaddr", cap_addr, 32'h0000_0100);
        chk("berr_pulses", n_berr - be0, 1);

        // illegal byte enable
        awv0 = n_awv;
        do_store(32'h0000_2000, 4'b0101, 32'h1111_2222, sc);
        chk("illegal_stall_cycles", sc, 0);
        chk("illegal_awvalid_cycles", n_awv - awv0, 0);

        // reset while waiting for B
        b_dly = 30;
        st_addr = 32'h0000_3000; st_we = 4'b1111; st_rt = 32'h5555_AAAA; st_req = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!axi.bready && k < 20);
        chk("rst_reached_resp", axi.bready, 1);
        #1;
        rst_n = 1'b0;
        st_req = 1'b0;
        #1;
        chk("midrst_awvalid", axi.awvalid, 0);
        chk("midrst_wvalid", axi.wvalid, 0);
        chk("midrst_bready", axi.bready, 0);
        chk("midrst_stall", st_stall, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        b_dly = 0;
        @(posedge clk);
        #1;
        do_store(32'h8000_0400, 4'b0001, 32'h0000_003C, sc);
        chk("postrst_stall_cycles", sc, 3);
        chk("postrst_awaddr", cap_addr, 32'h0000_0400);
        chk("postrst_wdata", cap_data, 32'h3C3C_3C3C);
        chk("postrst_wstrb", cap_strb, 4'b1000);

        // randomized stores
        for (int i = 0; i < 300; i++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            b_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            we = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) != 0) begin
                while (!is_legal(we)) we = 4'($urandom_range(0, 15));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:30] = 2'b10;
            do_store(a, we, $urandom, sc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
